// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, depth constant and flattened-bus field extraction for regfile_sb.
package regfile_pkg;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int NRD_DEF = 2;
  localparam int RESET_VAL_DEF = 1;
  localparam int DEPTH_DEF = 2 ** AW_DEF;
  localparam int BUS_MAX = 256;
  // Fields up to 64 bits wide; buses up to BUS_MAX bits.
  function automatic logic [63:0] field(input logic [BUS_MAX-1:0] bus, input int k, input int w);
    logic [BUS_MAX-1:0] s;
    s = bus >> (k * w);
    return s[63:0] & ((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/regfile_sb_busy.sv
// regfile_sb_busy: pending-write scoreboard with hazard lookup and occupancy counter (REGFILE_SB_BYPASS_EN).
module regfile_sb_busy
  import regfile_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int NRD = NRD_DEF,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD-1:0]    rbusy,
  output logic              iss_stall,
  output logic [AW:0]       busy_cnt
);
  localparam int DEPTH = 2 ** AW;
  logic [DEPTH-1:0] busy, busy_eff, wmask;
  logic set, clr, inc, dec;
  always_comb begin
    wmask = '0;
    wmask[waddr] = we;
    busy_eff = busy;
`ifdef REGFILE_SB_BYPASS_EN
    busy_eff = busy & ~wmask;
`endif
    busy_eff[0] = (ZERO_R0 != 0) ? 1'b0 : busy_eff[0];
  end
  assign iss_stall = iss_valid && busy_eff[iss_addr];
  assign set = iss_valid && !iss_stall && !(ZERO_R0 != 0 && iss_addr == '0);
  assign clr = we && !(ZERO_R0 != 0 && waddr == '0);
  assign inc = set && !busy[iss_addr];
  // A same-address set supersedes the clear, so the entry stays occupied.
  assign dec = clr && busy[waddr] && !(set && iss_addr == waddr);
  for (genvar k = 0; k < NRD; k++) begin : g_rb
    assign rbusy[k] = busy_eff[AW'(field(BUS_MAX'(raddr), k, AW))];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
      busy_cnt <= '0;
    end else begin
      if (clr) busy[waddr] <= 1'b0;
      if (set) busy[iss_addr] <= 1'b1;
      busy_cnt <= busy_cnt + (AW+1)'(inc) - (AW+1)'(dec);
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with reset, optional zero r0 and write scoreboard (REGFILE_SB_BYPASS_EN).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NRD = NRD_DEF,
  parameter int RESET_VAL = RESET_VAL_DEF,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  output logic              iss_stall,
  output logic [AW:0]       busy_cnt
);
  localparam int DEPTH = 2 ** AW;
  logic [DW-1:0] mem [DEPTH];
  logic wr_ok;
  assign wr_ok = we && !(ZERO_R0 != 0 && waddr == '0);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(RESET_VAL);
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    always_comb begin
      ra = AW'(field(BUS_MAX'(raddr), k, AW));
      rd = mem[ra];
`ifdef REGFILE_SB_BYPASS_EN
      rd = (we && waddr == ra) ? wdata : rd;
`endif
      rd = (ZERO_R0 != 0 && ra == '0) ? '0 : rd;
    end
    assign rdata[k*DW +: DW] = rd;
  end
  regfile_sb_busy #(.AW(AW), .NRD(NRD), .ZERO_R0(ZERO_R0)) u_busy (
    .clk(clk),
    .rst_n(rst_n),
    .we(we),
    .waddr(waddr),
    .iss_valid(iss_valid),
    .iss_addr(iss_addr),
    .raddr(raddr),
    .rbusy(rbusy),
    .iss_stall(iss_stall),
    .busy_cnt(busy_cnt)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of regfile_sb with ZERO_R0=0 and ZERO_R0=1 instances (REGFILE_SB_BYPASS_EN aware).
module tb_regfile_sb;
`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk, rst_n, we, iss_valid;
  logic [4:0] waddr, iss_addr;
  logic [31:0] wdata;
  logic [9:0] raddr;
  logic [63:0] rdata, zrdata;
  logic [1:0] rbusy, zrbusy;
  logic iss_stall, zstall;
  logic [5:0] busy_cnt, zcnt;
  int errors = 0;
  int checks = 0;

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .iss_valid(iss_valid),
    .iss_addr(iss_addr), .iss_stall(iss_stall), .busy_cnt(busy_cnt)
  );
  regfile_sb #(.ZERO_R0(1)) dz (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(zrdata), .rbusy(zrbusy), .iss_valid(iss_valid),
    .iss_addr(iss_addr), .iss_stall(zstall), .busy_cnt(zcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'hDEAD;
    tick();
    rst_n = 1'b1; we = 1'b0;
    for (int a = 0; a < 32; a += 3) begin
      raddr = {5'(a), 5'(a + 1)};
      #1;
      checks++;
      if (rdata !== {32'h1, 32'h1}) begin errors++; $display("FAIL reset_rdata a=%0d got %h exp %h", a, rdata, {32'h1, 32'h1}); end
    end
    checks++;
    if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", busy_cnt); end
    checks++;
    if (rbusy !== 2'b00) begin errors++; $display("FAIL reset_rbusy got %b exp 00", rbusy); end
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr = {5'd7, 5'd7};
    #1;
    checks++;
    if (rdata[31:0] !== (BYP ? 32'hA5A5A5A5 : 32'h1)) begin errors++; $display("FAIL wr_same_cycle got %h exp %h", rdata[31:0], BYP ? 32'hA5A5A5A5 : 32'h1); end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin errors++; $display("FAIL wr_next_cycle got %h exp %h", rdata, {32'hA5A5A5A5, 32'hA5A5A5A5}); end
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_addr = 5'd9;
    #1;
    checks++;
    if (iss_stall !== 1'b0) begin errors++; $display("FAIL sb_first_stall got %b exp 0", iss_stall); end
    tick();
    iss_valid = 1'b0; raddr = {5'd5, 5'd9};
    #1;
    checks++;
    if (rbusy !== 2'b01) begin errors++; $display("FAIL sb_rbusy got %b exp 01", rbusy); end
    checks++;
    if (busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_cnt_set got %0d exp 1", busy_cnt); end
    iss_valid = 1'b1;
    #1;
    checks++;
    if (iss_stall !== 1'b1) begin errors++; $display("FAIL sb_waw_stall got %b exp 1", iss_stall); end
    tick();
    iss_valid = 1'b0;
    #1;
    checks++;
    if (busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_cnt_stalled got %0d exp 1", busy_cnt); end
    we = 1'b1; waddr = 5'd9; wdata = 32'h1234; raddr = {5'd9, 5'd9};
    #1;
    checks++;
    if (rbusy !== (BYP ? 2'b00 : 2'b11)) begin errors++; $display("FAIL sb_rbusy_wcycle got %b exp %b", rbusy, BYP ? 2'b00 : 2'b11); end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (busy_cnt !== 6'd0) begin errors++; $display("FAIL sb_cnt_clear got %0d exp 0", busy_cnt); end
    checks++;
    if (rbusy !== 2'b00 || rdata !== {32'h1234, 32'h1234}) begin errors++; $display("FAIL sb_after_wb got rbusy=%b rdata=%h exp 00 %h", rbusy, rdata, {32'h1234, 32'h1234}); end
  endtask

  task automatic test_set_clear();
    iss_valid = 1'b1; iss_addr = 5'd4;
    tick();
    iss_valid = 1'b1; iss_addr = 5'd4; we = 1'b1; waddr = 5'd4; wdata = 32'h44;
    #1;
    checks++;
    if (iss_stall !== !BYP) begin errors++; $display("FAIL sc_stall got %b exp %b", iss_stall, !BYP); end
    tick();
    iss_valid = 1'b0; we = 1'b0; raddr = {5'd4, 5'd4};
    #1;
    checks++;
    if (busy_cnt !== (BYP ? 6'd1 : 6'd0)) begin errors++; $display("FAIL sc_cnt got %0d exp %0d", busy_cnt, BYP ? 1 : 0); end
    checks++;
    if (rbusy !== (BYP ? 2'b11 : 2'b00)) begin errors++; $display("FAIL sc_rbusy got %b exp %b", rbusy, BYP ? 2'b11 : 2'b00); end
    we = 1'b1; waddr = 5'd4;
    tick();
    we = 1'b0;
    iss_valid = 1'b1; iss_addr = 5'd10;
    tick();
    iss_valid = 1'b1; iss_addr = 5'd11; we = 1'b1; waddr = 5'd10; wdata = 32'hAA;
    tick();
    iss_valid = 1'b0; we = 1'b0; raddr = {5'd10, 5'd11};
    #1;
    checks++;
    if (busy_cnt !== 6'd1 || rbusy !== 2'b01) begin errors++; $display("FAIL sc_diff got cnt=%0d rbusy=%b exp 1 01", busy_cnt, rbusy); end
    we = 1'b1; waddr = 5'd11;
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (busy_cnt !== 6'd0) begin errors++; $display("FAIL sc_cleanup got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_zero_r0();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; iss_valid = 1'b1; iss_addr = 5'd0; raddr = 10'd0;
    #1;
    checks++;
    if (zrdata !== 64'd0 || zstall !== 1'b0) begin errors++; $display("FAIL z_same_cycle got %h stall=%b exp 0 0", zrdata, zstall); end
    tick();
    we = 1'b0; iss_valid = 1'b0;
    #1;
    checks++;
    if (zrdata !== 64'd0 || zrbusy !== 2'b00 || zcnt !== 6'd0) begin errors++; $display("FAIL z_after got rdata=%h rbusy=%b cnt=%0d exp 0 00 0", zrdata, zrbusy, zcnt); end
    checks++;
    if (rdata !== 64'hFFFFFFFF_FFFFFFFF || rbusy !== 2'b11 || busy_cnt !== 6'd1) begin errors++; $display("FAIL r0_plain got rdata=%h rbusy=%b cnt=%0d exp all-ones 11 1", rdata, rbusy, busy_cnt); end
    we = 1'b1; waddr = 5'd0; wdata = 32'h0;
    tick();
    we = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      iss_valid = 1'b1; iss_addr = 5'(i);
      tick();
    end
    iss_valid = 1'b0;
    #1;
    checks++;
    if (busy_cnt !== 6'b100000) begin errors++; $display("FAIL fill_cnt got %0d exp 32", busy_cnt); end
    checks++;
    if (zcnt !== 6'd31) begin errors++; $display("FAIL fill_zcnt got %0d exp 31", zcnt); end
    iss_valid = 1'b1; iss_addr = 5'd31; raddr = {5'd31, 5'd0};
    #1;
    checks++;
    if (iss_stall !== 1'b1 || rbusy !== 2'b11 || zrbusy !== 2'b10) begin errors++; $display("FAIL fill_flags got stall=%b rbusy=%b zrbusy=%b exp 1 11 10", iss_stall, rbusy, zrbusy); end
    iss_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i * 3);
      tick();
      if (i == 0) begin
        checks++;
        if (busy_cnt !== 6'd31) begin errors++; $display("FAIL wb_first got %0d exp 31", busy_cnt); end
      end
    end
    we = 1'b0; raddr = {5'd31, 5'd20};
    #1;
    checks++;
    if (busy_cnt !== 6'd0 || zcnt !== 6'd0) begin errors++; $display("FAIL wb_cnt got %0d/%0d exp 0/0", busy_cnt, zcnt); end
    checks++;
    if (rdata !== {32'd93, 32'd60}) begin errors++; $display("FAIL wb_data got %h exp %h", rdata, {32'd93, 32'd60}); end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0; iss_valid = 1'b0; iss_addr = '0;
    test_reset();
    test_write_read();
    test_scoreboard();
    test_set_clear();
    test_zero_r0();
    test_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the team's 32x32 register file. Adds configurable width, depth and read-port count.
- Adds synchronous active-low reset of the whole array, optional hardwired-zero r0 and a per-register pending-write scoreboard with an occupancy counter.
- Sits between the decode/issue stage, which reads operands and marks destinations, and the writeback stage, which writes results and clears marks.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2**AW entries.
- NRD, 2, number of independent read ports (1..4).
- RESET_VAL, 1, value every entry takes on reset, zero-extended or truncated to DW.
- ZERO_R0, 0, 1 = entry 0 always reads 0, ignores writes and never becomes busy.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  DW  write data.
- raddr  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rdata  out  NRD*DW  read data; port k occupies bits [k*DW +: DW].
- rbusy  out  NRD  busy flag of each read port's addressed register.
- iss_valid  in  1  issue request marking iss_addr as pending-write.
- iss_addr  in  AW  destination register being issued.
- iss_stall  out  1  issue must not proceed (hazard).
- busy_cnt  out  AW+1  registered count of busy registers.

Behaviour:
- Reset: when rst_n=0 at a rising edge, all entries become RESET_VAL, all busy bits 0 and busy_cnt 0. This overrides we and iss_valid in the same cycle.
- Reads are combinational, zero-cycle latency: rdata[k] = array[raddr[k]]. With ZERO_R0=1, raddr=0 returns 0 regardless of array content or bypass.
- Write: on the rising edge with rst_n=1 and we=1, array[waddr] <= wdata. With ZERO_R0=1 and waddr=0 the array is unchanged.
- Scoreboard set: a busy bit is set on the rising edge with iss_valid=1 and iss_stall=0. Ignored for iss_addr=0 when ZERO_R0=1.
- Scoreboard clear: a write with we=1 clears busy[waddr] on the same edge.
- Simultaneous set and clear of the same address: set wins, because the new producer supersedes. busy_cnt is unchanged in that case.
- rbusy[k] = busy[raddr[k]], combinational from the registered bits. Always 0 for address 0 when ZERO_R0=1.
- iss_stall = iss_valid AND busy[iss_addr] (WAW hazard). Uses the same bypass rule as rbusy.
- busy_cnt tracking:
  - +1 on an accepted set of a non-busy register.
  - -1 on a clear of a busy register without a simultaneous set.
  - Net 0 when an accepted set and a clear hit different registers in the same cycle.
  - Never wraps. Saturation is impossible by construction (at most 2**AW, fits in AW+1 bits).
- Write to a non-busy register: data is written and busy_cnt is unchanged.
- Multiple read ports addressing the same register return identical data.

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined:
  - A read port whose raddr equals waddr while we=1 returns wdata in the same cycle (write-through), subject to the ZERO_R0 rule.
  - rbusy and iss_stall see the busy bit as already cleared for that address.
- Undefined:
  - Reads return the old array value during the write cycle; the new value is visible the next cycle.
  - rbusy and iss_stall reflect the registered busy bits only.

Decomposition:
- Shared package regfile_pkg holds:
  - default DW/AW/NRD constants and the RESET_VAL default;
  - a function that extracts port k's address or data slice from the flattened buses;
  - a localparam for the depth, 2**AW.
- One sub-module, regfile_sb_busy: the busy-bit vector, set/clear priority, the iss_stall/rbusy lookup and the busy_cnt counter. The top holds the array, the read muxes and the bypass.

Test Plan:
- Reset: hold rst_n=0 for 1 cycle with we=1, waddr=3, wdata=0xDEAD -> every raddr reads 0x00000001, busy_cnt=0, rbusy=0; the write is discarded.
- Write then read: we=1, waddr=7, wdata=0xA5A5A5A5.
  - Same cycle, raddr0=7 -> 0xA5A5A5A5 if BYPASS_EN, else 0x00000001.
  - Next cycle -> 0xA5A5A5A5 on both ports.
- Scoreboard:
  - iss_valid=1, iss_addr=9 -> next cycle rbusy=1 for raddr=9, busy_cnt=1.
  - Second iss to 9 -> iss_stall=1, busy_cnt stays 1.
  - we=1, waddr=9 -> busy clears, busy_cnt=0.
- Simultaneous set and clear: reg 4 busy; same cycle iss_valid=1, iss_addr=4 and we=1, waddr=4 -> iss_stall=1 without bypass (no set; write clears, busy_cnt 1->0); with bypass no stall (set wins, busy stays 1, busy_cnt stays 1).
- ZERO_R0=1: we=1, waddr=0, wdata=0xFFFF_FFFF; iss_addr=0 -> raddr=0 reads 0, rbusy=0, busy_cnt unchanged.
- Fill: issue all 32 registers with ZERO_R0=0, one per cycle -> busy_cnt=32 (6'b100000); writeback all -> busy_cnt returns to 0 with no wrap.
